// File: rtl/swd_pkg.sv
// Shared SWD definitions: controller states, ACK codes, phase lengths and header builder.
// Used by both the host transmitter and the receive side.
package swd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_TRN1,
    ST_ACK,
    ST_TRN2,
    ST_WDATA,
    ST_RDATA,
    ST_TRN3,
    ST_DONE
  } swd_state_e;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int HDR_BITS  = 8;
  localparam int TRN_BITS  = 1;
  localparam int ACK_BITS  = 3;
  localparam int DATA_BITS = 33;
  localparam int BIT_CNT_W = 6;

  // Request header, bit 0 goes out first: start, APnDP, RnW, A2, A3, parity, stop, park.
  function automatic logic [7:0] swd_header(input logic apndp, input logic rnw,
                                            input logic [1:0] addr);
    return {1'b1, 1'b0, ^{apndp, rnw, addr}, addr[1], addr[0], rnw, apndp, 1'b1};
  endfunction

endpackage

// File: rtl/swd_bit_timer.sv
// SWCLK generator: each bit is CLK_DIV clocks low then CLK_DIV clocks high.
// drive_stb marks the edge that opens the next low phase; sample_stb the edge where swclk rises.
module swd_bit_timer #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic swclk,
  output logic drive_stb,
  output logic sample_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          tc;

  assign tc = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= CNT_LOAD;
      phase <= 1'b0;
    end else if (tc) begin
      cnt   <= CNT_LOAD;
      phase <= ~phase;
    end else begin
      cnt   <= cnt - 1'b1;
    end
  end

  assign swclk      = phase;
  assign sample_stb = en & ~phase & tc;
  assign drive_stb  = en & phase & tc;

endmodule

// File: rtl/swd_host_tx.sv
// SWD host transaction engine: sends the request header, reads ACK, then moves write or read data.
// state | meaning
// IDLE  | waiting for start, host drives swdio low
// HDR   | 8 request header bits driven by host
// TRN1  | turnaround to target
// ACK   | 3 ACK bits sampled from target
// TRN2  | turnaround back to host before write data
// WDATA | 32 write bits plus parity driven by host
// RDATA | 32 read bits plus parity sampled from target
// TRN3  | final turnaround after read data or a non-OK ACK
// DONE  | one-cycle completion pulse
module swd_host_tx
  import swd_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        apndp,
  input  logic        rnw,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [2:0]  ack,
  output logic [31:0] rdata,
  output logic        parity_err,
  output logic        swclk,
  output logic        swdio_o,
  output logic        swdio_oe,
  input  logic        swdio_i
);

  swd_state_e             state, state_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [31:0]            tx_sh, tx_sh_nxt;
  logic                   swdio_o_nxt, swdio_oe_nxt;
  logic                   req_rnw;
  logic [31:0]            req_wdata;
  logic                   accept;
  logic                   drive_stb, sample_stb;
  logic [7:0]             hdr;

  assign busy   = (state != ST_IDLE) && (state != ST_DONE);
  assign done   = (state == ST_DONE);
  assign accept = (state == ST_IDLE) && start;
  assign hdr    = swd_header(apndp, rnw, addr);

  swd_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy),
    .swclk     (swclk),
    .drive_stb (drive_stb),
    .sample_stb(sample_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Bit counter holds the bits remaining after the current one; new values land on drive_stb.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    tx_sh_nxt    = tx_sh;
    swdio_o_nxt  = swdio_o;
    swdio_oe_nxt = swdio_oe;
    if (drive_stb && bit_cnt != '0) bit_cnt_nxt = bit_cnt - 1'b1;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt    = ST_HDR;
          bit_cnt_nxt  = BIT_CNT_W'(HDR_BITS - 1);
          swdio_o_nxt  = hdr[0];
          swdio_oe_nxt = 1'b1;
          tx_sh_nxt    = {25'b0, hdr[7:1]};
        end
      end
      ST_HDR, ST_WDATA: begin
        if (drive_stb) begin
          if (bit_cnt == '0) begin
            state_nxt    = (state == ST_HDR) ? ST_TRN1 : ST_DONE;
            bit_cnt_nxt  = BIT_CNT_W'(TRN_BITS - 1);
            swdio_o_nxt  = 1'b0;
            swdio_oe_nxt = (state == ST_WDATA);
          end else begin
            swdio_o_nxt = tx_sh[0];
            tx_sh_nxt   = {1'b0, tx_sh[31:1]};
          end
        end
      end
      ST_TRN1: begin
        if (drive_stb) begin
          state_nxt   = ST_ACK;
          bit_cnt_nxt = BIT_CNT_W'(ACK_BITS - 1);
        end
      end
      ST_ACK: begin
        if (drive_stb && bit_cnt == '0) begin
          if (ack == ACK_OK && req_rnw) begin
            state_nxt   = ST_RDATA;
            bit_cnt_nxt = BIT_CNT_W'(DATA_BITS - 1);
          end else begin
            state_nxt   = (ack == ACK_OK) ? ST_TRN2 : ST_TRN3;
            bit_cnt_nxt = BIT_CNT_W'(TRN_BITS - 1);
          end
        end
      end
      ST_TRN2: begin
        if (drive_stb) begin
          state_nxt    = ST_WDATA;
          bit_cnt_nxt  = BIT_CNT_W'(DATA_BITS - 1);
          swdio_o_nxt  = req_wdata[0];
          swdio_oe_nxt = 1'b1;
          tx_sh_nxt    = {^req_wdata, req_wdata[31:1]};
        end
      end
      ST_RDATA: begin
        if (drive_stb && bit_cnt == '0) begin
          state_nxt   = ST_TRN3;
          bit_cnt_nxt = BIT_CNT_W'(TRN_BITS - 1);
        end
      end
      ST_TRN3: begin
        if (drive_stb) begin
          state_nxt    = ST_DONE;
          swdio_o_nxt  = 1'b0;
          swdio_oe_nxt = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      tx_sh    <= '0;
      swdio_o  <= 1'b0;
      swdio_oe <= 1'b1;
    end else begin
      bit_cnt  <= bit_cnt_nxt;
      tx_sh    <= tx_sh_nxt;
      swdio_o  <= swdio_o_nxt;
      swdio_oe <= swdio_oe_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rnw   <= 1'b0;
      req_wdata <= '0;
    end else if (accept) begin
      req_rnw   <= rnw;
      req_wdata <= wdata;
    end
  end

  // rdata is only touched in RDATA, so non-OK transactions leave it as it was.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack        <= '0;
      rdata      <= '0;
      parity_err <= 1'b0;
    end else begin
      if (accept) parity_err <= 1'b0;
      if (sample_stb) begin
        if (state == ST_ACK) begin
          ack <= {swdio_i, ack[2:1]};
        end else if (state == ST_RDATA) begin
          if (bit_cnt != '0) rdata      <= {swdio_i, rdata[31:1]};
          else               parity_err <= swdio_i ^ (^rdata);
        end
      end
    end
  end

endmodule

// File: tb/tb_swd_host_tx.sv
// Directed bench for swd_host_tx with a behavioural SWD target and a scoreboard of expected results.
module tb_swd_host_tx;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        apndp = 1'b0;
  logic        rnw = 1'b0;
  logic [1:0]  addr = 2'b00;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, parity_err, swclk, swdio_o, swdio_oe, swdio_i;
  logic [2:0]  ack;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  swd_host_tx #(.CLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .apndp     (apndp),
    .rnw       (rnw),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .ack       (ack),
    .rdata     (rdata),
    .parity_err(parity_err),
    .swclk     (swclk),
    .swdio_o   (swdio_o),
    .swdio_oe  (swdio_oe),
    .swdio_i   (swdio_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Target model: resp[k] is what the target puts on the line during bit k.
  logic [45:0] resp = '1;
  logic [45:0] cap = '0;
  logic [45:0] oe_cap = '0;
  int          bit_idx = 0;
  logic [31:0] model_rdata = 32'h0;

  assign swdio_i = (bit_idx < 46) ? resp[bit_idx] : 1'b1;

  always @(negedge swclk) bit_idx++;

  always @(posedge swclk) begin
    if (bit_idx < 46) begin
      cap[bit_idx]    = swdio_oe & swdio_o;
      oe_cap[bit_idx] = swdio_oe;
    end
  end

  typedef struct {
    logic [45:0] cap;
    logic [45:0] oe;
    logic [2:0]  ack;
    logic [31:0] rdata;
    logic        perr;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic a_apndp, input logic a_rnw, input logic [1:0] a_addr,
                         input logic [31:0] a_wdata, input logic [2:0] t_ack,
                         input logic [31:0] t_data, input logic t_par, input bit poke_busy);
    exp_t e, got;
    logic ok;
    logic [7:0] h;
    int cyc;
    bit seen;
    ok = (t_ack == 3'b001);
    h  = {1'b1, 1'b0, a_apndp ^ a_rnw ^ a_addr[0] ^ a_addr[1], a_addr[1], a_addr[0],
          a_rnw, a_apndp, 1'b1};
    resp = '1;
    resp[11:9] = t_ack;
    if (a_rnw) begin
      resp[43:12] = t_data;
      resp[44]    = t_par;
    end
    e.cap = '0;
    e.cap[7:0] = h;
    e.oe = '0;
    e.oe[7:0] = 8'hFF;
    if (ok && !a_rnw) begin
      e.cap[45:13] = {^a_wdata, a_wdata};
      e.oe[45:13]  = '1;
    end
    if (ok && a_rnw) model_rdata = t_data;
    e.rdata  = model_rdata;
    e.perr   = ok && a_rnw && (t_par != ^t_data);
    e.ack    = t_ack;
    e.cycles = (ok ? 46 : 13) * 2 * DIV + 1;
    sb.push_back(e);

    @(negedge clk);
    apndp = a_apndp; rnw = a_rnw; addr = a_addr; wdata = a_wdata;
    cap = '0; oe_cap = '0; bit_idx = 0;
    start = 1'b1;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        apndp = ~a_apndp; rnw = ~a_rnw; addr = ~a_addr; wdata = ~a_wdata;
        check("busy_after_start", 64'(busy), 64'(1));
      end
      if (poke_busy && cyc == 60) start = 1'b1;
      if (poke_busy && cyc == 61) start = 1'b0;
      if (done) seen = 1;
    end
    check("done_seen", 64'(seen), 64'(1));
    got = sb.pop_front();
    check("cycles", 64'(cyc), 64'(got.cycles));
    check("ack", 64'(ack), 64'(got.ack));
    check("rdata", 64'(rdata), 64'(got.rdata));
    check("parity_err", 64'(parity_err), 64'(got.perr));
    check("host_bits", 64'(cap), 64'(got.cap));
    check("oe_bits", 64'(oe_cap), 64'(got.oe));
    check("busy_at_done", 64'(busy), 64'(0));
    check("oe_at_done", 64'(swdio_oe), 64'(1));
    check("o_at_done", 64'(swdio_o), 64'(0));
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_swclk"}, 64'(swclk), 64'(0));
    check({tag, "_swdio_o"}, 64'(swdio_o), 64'(0));
    check({tag, "_swdio_oe"}, 64'(swdio_oe), 64'(1));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_ack"}, 64'(ack), 64'(0));
    check({tag, "_rdata"}, 64'(rdata), 64'(0));
    check({tag, "_parity_err"}, 64'(parity_err), 64'(0));
  endtask

  initial begin
    int  cyc;
    bit  saw_done;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // DP write A[3:2]=01, header 0xA9
    run_txn(1'b0, 1'b0, 2'b01, 32'h5000_0000, 3'b001, 32'h0, 1'b0, 1'b0);
    // DP read A[3:2]=00, header 0xA5, good parity
    run_txn(1'b0, 1'b1, 2'b00, 32'h0, 3'b001, 32'h2BA0_1477, 1'b0, 1'b0);
    // same read, corrupted parity
    run_txn(1'b0, 1'b1, 2'b00, 32'h0, 3'b001, 32'h2BA0_1477, 1'b1, 1'b0);
    // AP write answered with WAIT
    run_txn(1'b1, 1'b0, 2'b11, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, 1'b0);
    // AP read answered with FAULT
    run_txn(1'b1, 1'b1, 2'b10, 32'h0, 3'b100, 32'hFFFF_0000, 1'b1, 1'b0);
    // write with a stray start pulse while busy
    run_txn(1'b1, 1'b0, 2'b10, 32'hA5C3_0F96, 3'b001, 32'h0, 1'b0, 1'b1);

    // abort a write during WDATA bit 10 with reset
    resp = '1;
    resp[11:9] = 3'b001;
    @(negedge clk);
    apndp = 1'b0; rnw = 1'b0; addr = 2'b10; wdata = 32'h1234_5678;
    bit_idx = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (bit_idx < 23 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_wdata_bit10", 64'(bit_idx), 64'(23));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    model_rdata = 32'h0;
    saw_done = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    check("no_done_after_abort", 64'(saw_done), 64'(0));

    run_txn(1'b0, 1'b0, 2'b11, 32'h0F0F_1234, 3'b001, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
